// File: rtl/ifu_fetch_if.sv
// ifu_fetch_if: bundles the instruction-fetch channels of ifu_fetch.
//   imem request : imem_req_valid/imem_req_ready/imem_addr
//   imem response: imem_rsp_valid/imem_rdata
//   decode output: out_valid/out_ready/out_cmd/out_pc
//   redirect     : redirect_valid/redirect_pc
//   fault flag   : misalign
// master = fetch stage side, slave = memory/decode/branch-unit side.
interface ifu_fetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_cmd;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        misalign;

  modport master (
    output imem_req_valid, imem_addr, out_valid, out_cmd, out_pc, misalign,
    input  imem_req_ready, imem_rsp_valid, imem_rdata, out_ready,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_addr, out_valid, out_cmd, out_pc, misalign,
    output imem_req_ready, imem_rsp_valid, imem_rdata, out_ready,
           redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch stage. Owns the fetch PC, keeps at most one
// instruction-memory read outstanding, buffers the returned word and hands
// it to decode over a valid/ready channel. Redirects restart fetch at a new
// PC and discard any in-flight work.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - ifu_fetch_if.master (imem request/response, decode output,
//          redirect input, misalign flag)
// Parameter RESET_PC: fetch PC after reset (4-byte aligned).
// Build option IFU_MISALIGN_CHECK_EN: when defined, a redirect to a
// non-word-aligned target parks the stage in S_FAULT and raises misalign;
// when undefined, redirect targets are force-aligned and misalign is 0.
//
// state   | meaning
// S_REQ   | request at pc_q presented to imem
// S_WAIT  | request accepted, waiting for response (drop_q: discard it)
// S_HOLD  | instruction buffered in cmd_q, offered to decode
// S_FAULT | misaligned redirect target reported (check build only)
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic         clk,
  input  logic         rst,
  ifu_fetch_if.master  bus
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
`ifdef IFU_MISALIGN_CHECK_EN
    , S_FAULT = 2'd3
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;          // next fetch address
  logic [31:0] out_pc_q, out_pc_d;  // PC of the buffered instruction
  logic [31:0] cmd_q, cmd_d;
  logic        drop_q, drop_d;

  logic [31:0] redir_pc;
  state_e      redir_state;   // where a redirect lands when no drop is pending
  state_e      resume_state;  // where a completed drop lands (target in pc_q)

`ifdef IFU_MISALIGN_CHECK_EN
  assign redir_pc     = bus.redirect_pc;
  assign redir_state  = (bus.redirect_pc[1:0] != 2'b00) ? S_FAULT : S_REQ;
  assign resume_state = (pc_q[1:0] != 2'b00) ? S_FAULT : S_REQ;
`else
  assign redir_pc     = bus.redirect_pc & 32'hFFFF_FFFC;
  assign redir_state  = S_REQ;
  assign resume_state = S_REQ;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      out_pc_q <= RESET_PC;
      cmd_q    <= 32'd0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      out_pc_q <= out_pc_d;
      cmd_q    <= cmd_d;
      drop_q   <= drop_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    out_pc_d = out_pc_q;
    cmd_d    = cmd_q;
    drop_d   = drop_q;
    case (state_q)
      S_REQ: begin
        if (bus.imem_req_ready) begin
          out_pc_d = pc_q;
          pc_d     = pc_q + 32'd4;
          state_d  = S_WAIT;
        end
        if (bus.redirect_valid) begin
          pc_d = redir_pc;
          // An accepted request still returns data; it must be discarded.
          if (bus.imem_req_ready) drop_d = 1'b1;
          else                    state_d = redir_state;
        end
      end
      S_WAIT: begin
        if (bus.imem_rsp_valid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = resume_state;
          end else begin
            cmd_d   = bus.imem_rdata;
            state_d = S_HOLD;
          end
        end
        if (bus.redirect_valid) begin
          pc_d = redir_pc;
          if (bus.imem_rsp_valid) begin
            cmd_d   = cmd_q;
            drop_d  = 1'b0;
            state_d = redir_state;
          end else begin
            drop_d  = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (bus.redirect_valid) begin
          pc_d    = redir_pc;
          state_d = redir_state;
        end else if (bus.out_ready) begin
          state_d = S_REQ;
        end
      end
`ifdef IFU_MISALIGN_CHECK_EN
      S_FAULT: begin
        if (bus.redirect_valid) begin
          pc_d    = redir_pc;
          state_d = redir_state;
        end
      end
`endif
      default: state_d = S_REQ;
    endcase
  end

  always_comb begin
    // Reset qualification keeps the request quiet during the reset cycle itself.
    bus.imem_req_valid = (state_q == S_REQ) && !rst;
    bus.imem_addr      = pc_q;
    bus.out_valid      = (state_q == S_HOLD);
    bus.out_cmd        = cmd_q;
    bus.out_pc         = out_pc_q;
    bus.misalign       = 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
    if (state_q == S_FAULT) begin
      // The faulting target is still held in pc_q.
      bus.out_valid = 1'b1;
      bus.out_cmd   = 32'd0;
      bus.out_pc    = pc_q;
      bus.misalign  = 1'b1;
    end
`endif
  end

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] cmd;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc_cnt = 0;
  int   t_acc;
  logic [31:0] last_addr;
  logic [31:0] nxt;
  exp_t sb[$];

  ifu_fetch_if bus ();

  ifu_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expect a request in the current cycle and accept it.
  task automatic accept_req(input logic [31:0] exp_addr);
    chk("req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
    chk("req_addr", bus.imem_addr, exp_addr);
    chk("out_valid_in_req", {31'd0, bus.out_valid}, 32'd0);
    last_addr = exp_addr;
    t_acc = cyc_cnt;
    bus.imem_req_ready = 1'b1;
    cyc();
    bus.imem_req_ready = 1'b0;
  endtask

  // Return data for last_addr after 'delay' idle cycles.
  task automatic respond(input int delay, input bit deliver);
    exp_t e;
    for (int i = 0; i < delay; i++) begin
      chk("wait_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
      chk("wait_out_valid", {31'd0, bus.out_valid}, 32'd0);
      cyc();
    end
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rdata     = mem_word(last_addr);
    if (deliver) begin
      e.pc  = last_addr;
      e.cmd = mem_word(last_addr);
      sb.push_back(e);
    end
    cyc();
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rdata     = 32'hDEAD_BEEF;
  endtask

  // Stall decode for 'stall' cycles, then consume and score the instruction.
  task automatic consume(input int stall, input bit with_redirect, input logic [31:0] rpc);
    exp_t e;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL sb_empty: observed 0 entries expected >0");
    end
    e = (sb.size() > 0) ? sb[0] : '0;
    for (int i = 0; i < stall; i++) begin
      bus.out_ready = 1'b0;
      chk("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("stall_out_pc", bus.out_pc, e.pc);
      chk("stall_out_cmd", bus.out_cmd, e.cmd);
      chk("stall_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
      cyc();
    end
    bus.out_ready = 1'b1;
    if (with_redirect) begin
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = rpc;
    end
    chk("out_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("out_pc", bus.out_pc, e.pc);
    chk("out_cmd", bus.out_cmd, e.cmd);
    if (sb.size() > 0) void'(sb.pop_front());
    cyc();
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
  endtask

  initial begin
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rdata     = 32'd0;
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;

    // Reset values.
    cyc(); cyc(); cyc();
    chk("rst_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_cmd", bus.out_cmd, 32'd0);
    chk("rst_out_pc", bus.out_pc, RESET_PC);
    chk("rst_misalign", {31'd0, bus.misalign}, 32'd0);
    rst = 1'b0;
    #1;
    chk("first_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
    chk("post_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("post_rst_out_pc", bus.out_pc, RESET_PC);
    chk("post_rst_out_cmd", bus.out_cmd, 32'd0);

    // Back-to-back sequential fetch at peak rate.
    nxt = RESET_PC;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) chk("fetch_spacing", cyc_cnt - t_acc, 32'd3);
      accept_req(nxt);
      respond(0, 1'b1);
      consume(0, 1'b0, 32'd0);
      nxt = nxt + 32'd4;
    end
    chk("fetch_spacing", cyc_cnt - t_acc, 32'd3);

    // Decode stall for 5 cycles.
    accept_req(32'h8000_000C);
    respond(0, 1'b1);
    consume(5, 1'b0, 32'd0);

    // Redirect while waiting; response shows up 3 cycles after it.
    accept_req(32'h8000_0010);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0100;
    cyc();
    bus.redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("drop_wait_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("drop_wait_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
      cyc();
    end
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rdata     = mem_word(32'h8000_0010);
    cyc();
    bus.imem_rsp_valid = 1'b0;
    chk("dropped_out_valid", {31'd0, bus.out_valid}, 32'd0);
    accept_req(32'h8000_0100);
    respond(0, 1'b1);

    // Redirect together with consume in S_HOLD.
    consume(0, 1'b1, 32'h8000_0200);
    chk("hold_redir_out_valid", {31'd0, bus.out_valid}, 32'd0);
    accept_req(32'h8000_0200);
    respond(1, 1'b1);
    consume(0, 1'b0, 32'd0);

    // Redirect in the same cycle the request is accepted.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0300;
    accept_req(32'h8000_0204);
    bus.redirect_valid = 1'b0;
    respond(0, 1'b0);
    accept_req(32'h8000_0300);

    // Redirect in the same cycle the response arrives.
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rdata     = mem_word(32'h8000_0300);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0400;
    cyc();
    bus.imem_rsp_valid = 1'b0;
    bus.redirect_valid = 1'b0;
    accept_req(32'h8000_0400);
    respond(0, 1'b1);
    consume(0, 1'b0, 32'd0);

    // Redirect in S_REQ without acceptance, then PC wrap.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    cyc();
    bus.redirect_valid = 1'b0;
    accept_req(32'hFFFF_FFFC);
    respond(2, 1'b1);
    consume(0, 1'b0, 32'd0);
    accept_req(32'h0000_0000);
    respond(0, 1'b1);
    consume(0, 1'b0, 32'd0);

    // Repeated redirects while waiting: last one wins.
    accept_req(32'h0000_0004);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0500;
    cyc();
    bus.redirect_pc    = 32'h8000_0600;
    cyc();
    bus.redirect_valid = 1'b0;
    cyc();
    respond(0, 1'b0);
    accept_req(32'h8000_0600);
    respond(0, 1'b1);
    consume(0, 1'b0, 32'd0);

    // Misaligned redirect target.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0102;
    cyc();
    bus.redirect_valid = 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("fault_misalign", {31'd0, bus.misalign}, 32'd1);
      chk("fault_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("fault_out_pc", bus.out_pc, 32'h8000_0102);
      chk("fault_out_cmd", bus.out_cmd, 32'd0);
      chk("fault_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
      cyc();
    end
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0700;
    cyc();
    bus.redirect_valid = 1'b0;
    chk("fault_exit_misalign", {31'd0, bus.misalign}, 32'd0);
    nxt = 32'h8000_0700;
`else
    chk("align_misalign", {31'd0, bus.misalign}, 32'd0);
    nxt = 32'h8000_0100;
`endif
    accept_req(nxt);
    respond(0, 1'b1);
    consume(0, 1'b0, 32'd0);
    nxt = nxt + 32'd4;

    // Reset with a request in flight; the late response is ignored.
    accept_req(nxt);
    rst = 1'b1;
    cyc();
    chk("mid_rst_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
    chk("mid_rst_out_pc", bus.out_pc, RESET_PC);
    rst = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rdata     = mem_word(nxt);
    #1;
    chk("after_rst_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
    chk("after_rst_addr", bus.imem_addr, RESET_PC);
    cyc();
    bus.imem_rsp_valid = 1'b0;
    chk("late_rsp_out_valid", {31'd0, bus.out_valid}, 32'd0);
    accept_req(RESET_PC);
    respond(0, 1'b1);
    consume(0, 1'b0, 32'd0);
    chk("sb_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
